// File: rtl/psram_pkg.sv
// psram_pkg: opcodes and FSM state encoding shared by the SPI PSRAM responder.
package psram_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_RDID  = 8'h9F;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    READ   = 3'd3,
    WRITE  = 3'd4,
    ID     = 3'd5,
    IGNORE = 3'd6
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-flop synchronisers for the SPI pins plus edge pulses.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   sck, cs, mosi     raw asynchronous SPI pins
//   sck_rise/sck_fall one-clk pulses on synchronised sck edges
//   cs_sync, cs_fall  synchronised chip select and its falling-edge pulse
//   mosi_sync         synchronised data, aligned with the sck edge pulses
module spi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic sck,
  input  logic cs,
  input  logic mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_sync,
  output logic cs_fall,
  output logic mosi_sync
);

  logic [1:0] sck_ff;
  logic [1:0] cs_ff;
  logic [1:0] mosi_ff;
  logic       sck_prev;
  logic       cs_prev;

  // Reset values are the bus idle levels so no edge is seen coming out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_ff   <= 2'b00;
      cs_ff    <= 2'b11;
      mosi_ff  <= 2'b00;
      sck_prev <= 1'b0;
      cs_prev  <= 1'b1;
    end else begin
      sck_ff   <= {sck_ff[0], sck};
      cs_ff    <= {cs_ff[0], cs};
      mosi_ff  <= {mosi_ff[0], mosi};
      sck_prev <= sck_ff[1];
      cs_prev  <= cs_ff[1];
    end
  end

  assign sck_rise  = sck_ff[1] & ~sck_prev;
  assign sck_fall  = ~sck_ff[1] & sck_prev;
  assign cs_sync   = cs_ff[1];
  assign cs_fall   = ~cs_ff[1] & cs_prev;
  assign mosi_sync = mosi_ff[1];

endmodule

// File: rtl/spi_psram_responder.sv
// spi_psram_responder: SPI mode-0 responder emulating a PSRAM (read 03,
// write 02, optional read-ID 9F) in front of a byte-wide local memory.
// Optional feature macro: SPI_PSRAM_RESPONDER_READID_EN (builds the 9F path).
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   spi_esp32_sck/cs/mosi    SPI inputs (asynchronous to clk)
//   spi_esp32_miso           SPI data out, zero outside READ/ID
//   mem_addr, mem_wdata      local memory address / write byte
//   mem_we, mem_re           one-cycle write / read strobes
//   mem_rdata                read byte, valid one clk after mem_re
//   active                   high while a transaction is in progress
//
// state  | meaning
// IDLE   | waiting for a cs fall
// CMD    | shifting in the 8-bit opcode
// ADDR   | shifting in 24 address bits (also skipped bits for read-ID)
// READ   | streaming memory bytes out, prefetching the next address
// WRITE  | collecting bytes and strobing them into memory
// ID     | streaming MF_ID, KGD_ID, then zeros
// IGNORE | unknown opcode, idle until cs rises
import psram_pkg::*;

module spi_psram_responder #(
  parameter int          ADDR_W = 17,
  parameter logic [7:0]  MF_ID  = 8'h0D,
  parameter logic [7:0]  KGD_ID = 8'h5D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_esp32_sck,
  input  logic              spi_esp32_cs,
  input  logic              spi_esp32_mosi,
  output logic              spi_esp32_miso,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              active
);

  state_t state, state_nxt;

  logic sck_rise, sck_fall, cs_sync, cs_fall, mosi_sync;
  logic rise, fall;

  logic [4:0]        cnt;
  logic [7:0]        cmd_sh;
  logic [6:0]        rx_sh;
  logic [6:0]        tx_sh;
  logic [7:0]        nxt_byte;
  logic              miso_q;
  logic              re_d;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        flush;
  logic              armed;

  logic [7:0]        cmd_byte;
  logic [ADDR_W-1:0] addr_shift;

  spi_sync_edge u_sync (
    .clk       (clk),
    .rst       (rst),
    .sck       (spi_esp32_sck),
    .cs        (spi_esp32_cs),
    .mosi      (spi_esp32_mosi),
    .sck_rise  (sck_rise),
    .sck_fall  (sck_fall),
    .cs_sync   (cs_sync),
    .cs_fall   (cs_fall),
    .mosi_sync (mosi_sync)
  );

  // sck edges only count while the synchronised cs is low
  assign rise = sck_rise & ~cs_sync;
  assign fall = sck_fall & ~cs_sync;

  assign cmd_byte   = {cmd_sh[6:0], mosi_sync};
  assign addr_shift = {addr[ADDR_W-2:0], mosi_sync};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cs_sync && state != IDLE) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (cs_fall && armed) state_nxt = CMD;
        CMD: if (rise && cnt == 5'd7) begin
          if (cmd_byte == CMD_READ || cmd_byte == CMD_WRITE) state_nxt = ADDR;
`ifdef SPI_PSRAM_RESPONDER_READID_EN
          else if (cmd_byte == CMD_RDID) state_nxt = ADDR;
`else
          else if (cmd_byte == CMD_RDID) state_nxt = IGNORE;
`endif
          else state_nxt = IGNORE;
        end
        ADDR: if (rise && cnt == 5'd23) begin
          if (cmd_sh == CMD_READ) state_nxt = READ;
`ifdef SPI_PSRAM_RESPONDER_READID_EN
          else if (cmd_sh == CMD_RDID) state_nxt = ID;
`endif
          else state_nxt = WRITE;
        end
        default: ;
      endcase
    end
  end

`ifdef SPI_PSRAM_RESPONDER_READID_EN
  logic [1:0] id_idx;
`else
  // ID bytes have no consumer when read-ID is compiled out
  logic id_unused;
  assign id_unused = ^{MF_ID, KGD_ID};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      cmd_sh    <= '0;
      rx_sh     <= '0;
      tx_sh     <= '0;
      nxt_byte  <= '0;
      miso_q    <= 1'b0;
      re_d      <= 1'b0;
      addr      <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      flush     <= '0;
      armed     <= 1'b0;
`ifdef SPI_PSRAM_RESPONDER_READID_EN
      id_idx    <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      re_d   <= mem_re;

      // After reset the synchroniser needs two clocks to show the real cs;
      // arming only once cs is seen high keeps a still-low cs from looking
      // like a fresh fall.
      if (flush != 2'd2) flush <= flush + 2'd1;
      else if (cs_sync)  armed <= 1'b1;

      if (mem_we) addr <= addr + 1'b1;
      if (re_d)   nxt_byte <= mem_rdata;

      case (state)
        IDLE: begin
          cnt    <= '0;
          miso_q <= 1'b0;
        end
        CMD: if (rise) begin
          cmd_sh <= cmd_byte;
          cnt    <= (cnt == 5'd7) ? 5'd0 : cnt + 5'd1;
        end
        ADDR: if (rise) begin
          addr <= addr_shift;
          if (cnt == 5'd23) begin
            cnt <= '0;
            if (cmd_sh == CMD_READ) mem_re <= 1'b1;
`ifdef SPI_PSRAM_RESPONDER_READID_EN
            if (cmd_sh == CMD_RDID) begin
              nxt_byte <= MF_ID;
              id_idx   <= 2'd1;
            end
`endif
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        WRITE: if (rise) begin
          rx_sh <= {rx_sh[5:0], mosi_sync};
          if (cnt == 5'd7) begin
            cnt       <= '0;
            mem_we    <= 1'b1;
            mem_wdata <= {rx_sh, mosi_sync};
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
`ifdef SPI_PSRAM_RESPONDER_READID_EN
        READ, ID: begin
`else
        READ: begin
`endif
          // First rise of each byte fetches the following byte so it is
          // waiting in nxt_byte by the fall after bit 7.
          if (rise) begin
            cnt <= (cnt == 5'd7) ? 5'd0 : cnt + 5'd1;
            if (cnt == 5'd0) begin
              if (state == READ) begin
                addr   <= addr + 1'b1;
                mem_re <= 1'b1;
              end
`ifdef SPI_PSRAM_RESPONDER_READID_EN
              else begin
                nxt_byte <= (id_idx == 2'd1) ? KGD_ID : 8'h00;
                id_idx   <= 2'd2;
              end
`endif
            end
          end
          if (fall) begin
            if (cnt == 5'd0) {miso_q, tx_sh} <= nxt_byte;
            else             {miso_q, tx_sh} <= {tx_sh, 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SPI_PSRAM_RESPONDER_READID_EN
  assign spi_esp32_miso = (state == READ || state == ID) ? miso_q : 1'b0;
`else
  assign spi_esp32_miso = (state == READ) ? miso_q : 1'b0;
`endif

  assign mem_addr = addr;
  assign active   = (state != IDLE);

endmodule

// File: tb/tb_spi_psram_responder.sv
module tb_spi_psram_responder;

  localparam int HALF = 80;   // sck half period in ns (16 clk per sck period)

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck = 1'b0;
  logic        cs = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [16:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata = 8'h00;
  logic        active;

  int checks = 0;
  int errors = 0;
  int overlap = 0;

  logic [7:0]  mem [int];
  logic [16:0] re_log [$];
  logic [16:0] we_addr_log [$];
  logic [7:0]  we_data_log [$];

  always #5 clk = ~clk;

  spi_psram_responder dut (
    .clk            (clk),
    .rst            (rst),
    .spi_esp32_sck  (sck),
    .spi_esp32_cs   (cs),
    .spi_esp32_mosi (mosi),
    .spi_esp32_miso (miso),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_we         (mem_we),
    .mem_re         (mem_re),
    .mem_rdata      (mem_rdata),
    .active         (active)
  );

  // Memory model: read data valid the clk after mem_re.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : 8'h00;
    if (mem_we) mem[int'(mem_addr)] = mem_wdata;
  end

  always @(negedge clk) begin
    if (mem_re) re_log.push_back(mem_addr);
    if (mem_we) begin
      we_addr_log.push_back(mem_addr);
      we_data_log.push_back(mem_wdata);
    end
    if (mem_re && mem_we) overlap++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bits(input int n, input logic [7:0] tx, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - n; i--) begin
      mosi = tx[i];
      #(HALF);
      sck = 1'b1;
      rx[i] = miso;
      #(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(8, tx, rx);
  endtask

  task automatic cs_start();
    cs = 1'b0;
    #(HALF);
  endtask

  task automatic cs_end();
    #(HALF);
    cs = 1'b1;
    #200;
  endtask

  task automatic clear_logs();
    re_log.delete();
    we_addr_log.delete();
    we_data_log.delete();
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [23:0] a);
    logic [7:0] d;
    logic [23:0] av;
    av = a;
    spi_byte(op, d);
    spi_byte(av[23:16], d);
    spi_byte(av[15:8], d);
    spi_byte(av[7:0], d);
  endtask

  initial begin
    logic [7:0] r0, r1, r2, dummy;

    // reset
    repeat (5) @(posedge clk);
    #3;
    check("rst_miso", miso, 0);
    check("rst_we", mem_we, 0);
    check("rst_re", mem_re, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_active", active, 0);
    rst = 1'b0;
    #100;

    // write 02 000010 A5 3C
    clear_logs();
    cs_start();
    send_hdr(8'h02, 24'h000010);
    check("wr_active", active, 1);
    spi_byte(8'hA5, dummy);
    spi_byte(8'h3C, dummy);
    cs_end();
    check("wr_count", we_addr_log.size(), 2);
    check("wr_addr0", we_addr_log[0], 17'h10);
    check("wr_data0", we_data_log[0], 8'hA5);
    check("wr_addr1", we_addr_log[1], 17'h11);
    check("wr_data1", we_data_log[1], 8'h3C);
    check("wr_no_re", re_log.size(), 0);
    check("wr_idle", active, 0);

    // read 03 000020, 3 bytes
    mem[32'h20] = 8'h11;
    mem[32'h21] = 8'h22;
    mem[32'h22] = 8'h33;
    clear_logs();
    cs_start();
    send_hdr(8'h03, 24'h000020);
    spi_byte(8'h00, r0);
    spi_byte(8'h00, r1);
    spi_byte(8'h00, r2);
    cs_end();
    check("rd_b0", r0, 8'h11);
    check("rd_b1", r1, 8'h22);
    check("rd_b2", r2, 8'h33);
    check("rd_re_cnt", re_log.size() >= 3, 1);
    check("rd_re0", re_log[0], 17'h20);
    check("rd_re1", re_log[1], 17'h21);
    check("rd_re2", re_log[2], 17'h22);
    check("rd_no_we", we_addr_log.size(), 0);

    // wrap: upper address bits dropped, 1FFFF -> 00000
    mem[32'h1FFFF] = 8'h77;
    mem[32'h0]     = 8'h88;
    clear_logs();
    cs_start();
    send_hdr(8'h03, 24'hF1FFFF);
    spi_byte(8'h00, r0);
    spi_byte(8'h00, r1);
    cs_end();
    check("wrap_re_cnt", re_log.size() >= 2, 1);
    check("wrap_re0", re_log[0], 17'h1FFFF);
    check("wrap_re1", re_log[1], 17'h00000);
    check("wrap_b0", r0, 8'h77);
    check("wrap_b1", r1, 8'h88);

    // abort after 5 data bits of a write
    clear_logs();
    cs_start();
    send_hdr(8'h02, 24'h000040);
    spi_bits(5, 8'hFF, dummy);
    #(HALF);
    check("abort_busy", active, 1);
    cs = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_idle3", active, 0);
    #200;
    check("abort_no_we", we_addr_log.size(), 0);
    clear_logs();
    cs_start();
    send_hdr(8'h03, 24'h000021);
    spi_byte(8'h00, r0);
    cs_end();
    check("abort_rd_b0", r0, 8'h22);
    check("abort_rd_re0", re_log[0], 17'h21);

    // read-ID
    clear_logs();
    cs_start();
    send_hdr(8'h9F, 24'h000000);
    spi_byte(8'h00, r0);
    spi_byte(8'h00, r1);
    spi_byte(8'h00, r2);
    cs_end();
`ifdef SPI_PSRAM_RESPONDER_READID_EN
    check("id_b0", r0, 8'h0D);
    check("id_b1", r1, 8'h5D);
`else
    check("id_b0", r0, 8'h00);
    check("id_b1", r1, 8'h00);
`endif
    check("id_b2", r2, 8'h00);
    check("id_no_re", re_log.size(), 0);

    // unknown opcode
    clear_logs();
    cs_start();
    spi_byte(8'hAB, dummy);
    spi_byte(8'hFF, r0);
    spi_byte(8'hFF, r1);
    check("ign_active", active, 1);
    cs_end();
    check("ign_miso", {r0, r1}, 16'h0000);
    check("ign_no_strobe", re_log.size() + we_addr_log.size(), 0);

    // reset mid-write: no strobe, stay idle while cs is still low
    clear_logs();
    cs_start();
    send_hdr(8'h02, 24'h000050);
    spi_bits(4, 8'hF0, dummy);
    rst = 1'b1;
    #50;
    rst = 1'b0;
    spi_bits(4, 8'h0F, dummy);
    spi_byte(8'hEE, dummy);
    check("rstmid_idle", active, 0);
    cs_end();
    check("rstmid_no_we", we_addr_log.size(), 0);

    // next transaction after reset works
    clear_logs();
    cs_start();
    send_hdr(8'h02, 24'h000005);
    spi_byte(8'hC3, dummy);
    cs_end();
    check("post_we_cnt", we_addr_log.size(), 1);
    check("post_we_addr", we_addr_log[0], 17'h5);
    check("post_we_data", we_data_log[0], 8'hC3);

    check("no_we_re_overlap", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_psram_responder.md
SPI_PSRAM_RESPONDER -- requirements
Module: spi_psram_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 17, width of the local memory byte address.
REQ-002 SHALL have parameter MF_ID, default 8'h0D, manufacturer ID byte.
REQ-003 SHALL have parameter KGD_ID, default 8'h5D, known-good-die ID byte.
REQ-004 SHALL have port clk  input  1  system clock; sole clock domain.
REQ-005 SHALL have port rst  input  1  reset, synchronous to clk, active-high.
REQ-006 SHALL have port spi_esp32_sck  input  1  SPI clock from ESP32, mode 0, asynchronous to clk.
REQ-007 SHALL have port spi_esp32_cs  input  1  chip select, active-low, asynchronous.
REQ-008 SHALL have port spi_esp32_mosi  input  1  serial data in, MSB first.
REQ-009 SHALL have port spi_esp32_miso  output  1  serial data out, MSB first.
REQ-010 SHALL have port mem_addr  output  ADDR_W  byte address for the local memory.
REQ-011 SHALL have ports mem_wdata  output  8  write byte, and mem_we  output  1  one-cycle write strobe.
REQ-012 SHALL have ports mem_re  output  1  one-cycle read strobe, and mem_rdata  input  8  valid exactly one clk after mem_re.
REQ-013 SHALL have port active  output  1  high while a transaction is in progress (LED and status use).

Function
REQ-014 SHALL pass sck, cs and mosi through 2-flop synchronisers; edges are detected on the synchronised sck; supported f_sck <= f_clk/8.
REQ-015 SHALL implement states IDLE, CMD, ADDR, READ, WRITE, ID, IGNORE.
REQ-016 SHALL go IDLE->CMD on a synchronised cs fall; it SHALL sample mosi on each sck rise and shift miso on each sck fall.
REQ-017 SHALL, after 8 command bits: 8'h03 -> ADDR (read), 8'h02 -> ADDR (write), 8'h9F -> ID (only with the macro in REQ-031), any other value -> IGNORE.
REQ-018 SHALL collect 24 address bits MSB first, keep the low ADDR_W bits and silently drop the upper bits.
REQ-019 SHALL, on a read, pulse mem_re in the cycle after the 24th address rise, load mem_rdata into the TX shifter, and drive its MSB on the next sck fall.
REQ-020 SHALL prefetch during a read by pulsing mem_re at addr+1 on the first sck rise of each byte, so the next byte's MSB is ready on the fall after bit 7.
REQ-021 SHALL, on a write, after every 8th received bit pulse mem_we for exactly one cycle with that byte's address and data, then increment the address.
REQ-022 SHALL increment the address modulo 2^ADDR_W; after all-ones it SHALL continue at 0.
REQ-023 SHALL drive spi_esp32_miso to 0 in every state except READ and ID.
REQ-024 SHALL on cs rise, in any state and mid-byte, return to IDLE within 3 clk; a partial write byte SHALL be discarded with no mem_we.
REQ-025 SHALL ignore sck edges while the synchronised cs is high.
REQ-026 SHALL never assert mem_we and mem_re in the same cycle.
REQ-027 SHALL drive active high from the cs-fall detection until the return to IDLE.

Reset
REQ-028 SHALL on rst enter IDLE with spi_esp32_miso=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, active=0, synchroniser flops at idle levels (cs=1, sck=0).
REQ-029 SHALL, if rst is asserted mid-transaction, abort without a memory strobe and remain in IDLE until the next cs fall after rst deasserts.

Configuration
REQ-030 SHALL support macro SPI_PSRAM_RESPONDER_READID_EN.
REQ-031 SHALL with the macro defined decode 8'h9F, skip 24 address bits, then return MF_ID, then KGD_ID, then 8'h00 repeated; without it 8'h9F SHALL go to IGNORE and the ID logic SHALL not be built.

Structure
REQ-032 SHALL take the command opcodes (03/02/9F) and the state encoding from a shared package psram_pkg.
REQ-033 SHALL contain one sub-module spi_sync_edge (2-flop synchroniser plus rise/fall pulse generator).

Verification
REQ-034 SHALL verify write: cs low, 02 000010 A5 3C, cs high -> mem_we at addr 0x10 with A5, then at 0x11 with 3C.
REQ-035 SHALL verify read: memory[0x20..0x22]=11,22,33; send 03 000020 then clock 24 bits -> MISO returns 11 22 33, with mem_re issued at 0x20, 0x21, 0x22.
REQ-036 SHALL verify wrap: with ADDR_W=17, read at address 1FFFF for 2 bytes -> mem_re issued at 1FFFF, then 00000.
REQ-037 SHALL verify abort: raise cs after 5 data bits of a write -> no mem_we, IDLE within 3 clk, and the next 03 transaction is correct.
REQ-038 SHALL verify readid: send 9F 000000 then clock 24 bits -> MISO returns 0D 5D 00 with the macro defined, and 00 00 00 without it.
